mod_divider: RTL and testbench



---
 rtl/mod_divider_pkg.sv | 19 +
 rtl/mod_div_step.sv | 28 ++
 rtl/mod_divider.sv | 109 ++++++++++
 tb/tb_mod_divider.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_divider_pkg.sv
// Shared definitions for the multi-cycle restoring divider.
// State encoding and counter sizing helper.
package mod_divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

endpackage

// File: rtl/mod_div_step.sv
// One restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, shift the quotient bit in.
module mod_div_step #(
  parameter int W = 8
) (
  input  logic [W:0]     i_r,
  input  logic [2*W-1:0] i_q,
  input  logic [W-1:0]   i_cr,
  output logic [W:0]     o_r,
  output logic [2*W-1:0] o_q
);

  logic [W:0] w_t;
  logic [W:0] w_cr;
  logic       w_ge;
  logic       w_unused_msb;

  // The partial remainder top bit is always 0 between steps.
  assign w_unused_msb = i_r[W];

  assign w_t  = {i_r[W-1:0], i_q[2*W-1]};
  assign w_cr = {1'b0, i_cr};
  assign w_ge = (w_t >= w_cr);

  assign o_r = w_ge ? (w_t - w_cr) : w_t;
  assign o_q = {i_q[2*W-2:0], w_ge};

endmodule

// File: rtl/mod_divider.sv
// Multi-cycle divider: 2W-bit dividend by W-bit divisor, one
// quotient bit per clock, start/busy/done handshake.
module mod_divider
  import mod_divider_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [2*W-1:0] i_x,
  input  logic [W-1:0]   i_c,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_err,
  output logic [2*W-1:0] o_quo,
  output logic [W-1:0]   o_rem
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] CNT_INIT = CW'(2 * W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t         r_state;
  logic [W:0]     r_r;
  logic [2*W-1:0] r_q;
  logic [W-1:0]   r_cr;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_err;
  logic [2*W-1:0] r_quo;
  logic [W-1:0]   r_rem;

  logic [W:0]     w_r_nxt;
  logic [2*W-1:0] w_q_nxt;

  mod_div_step #(.W(W)) u_step (
    .i_r  (r_r),
    .i_q  (r_q),
    .i_cr (r_cr),
    .o_r  (w_r_nxt),
    .o_q  (w_q_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_r     <= '0;
      r_q     <= '0;
      r_cr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_quo   <= '0;
      r_rem   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_r    <= '0;
            r_q    <= i_x;
            r_cr   <= i_c;
            r_cnt  <= CNT_INIT;
            r_busy <= 1'b1;
            if (i_c == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_quo   <= '1;
              r_rem   <= i_x[W-1:0];
            end else begin
              r_state <= S_RUN;
              r_err   <= 1'b0;
            end
          end
        end
        S_RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_quo   <= w_q_nxt;
            r_rem   <= w_r_nxt[W-1:0];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_err  = r_err;
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

endmodule

// File: tb/tb_mod_divider.sv
// Self-checking bench for mod_divider at W=8 and W=32:
// table vectors, handshake corner cases, random regression.
module tb_mod_divider;

  typedef struct {
    logic [63:0] q;
    logic [31:0] r;
    logic        e;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  c;
    logic [15:0] q;
    logic [7:0]  r;
    logic        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s8 = 1'b0;
  logic [15:0] x8 = '0;
  logic [7:0]  c8 = '0;
  logic        b8, d8, e8;
  logic [15:0] q8;
  logic [7:0]  r8;

  logic        s32 = 1'b0;
  logic [63:0] x32 = '0;
  logic [31:0] c32 = '0;
  logic        b32, d32, e32;
  logic [63:0] q32;
  logic [31:0] r32;

  mod_divider #(.W(8)) u_dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (s8),
    .i_x     (x8),
    .i_c     (c8),
    .o_busy  (b8),
    .o_done  (d8),
    .o_err   (e8),
    .o_quo   (q8),
    .o_rem   (r8)
  );

  mod_divider #(.W(32)) u_dut32 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (s32),
    .i_x     (x32),
    .i_c     (c32),
    .o_busy  (b32),
    .o_done  (d32),
    .o_err   (e32),
    .o_quo   (q32),
    .o_rem   (r32)
  );

  int tests = 0;
  int fails = 0;

  exp_t sb8[$];
  exp_t sb32[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] x,
                                 input logic [31:0] c,
                                 input int w);
    exp_t m;
    if (c == '0) begin
      m.q = (w == 8) ? 64'hFFFF : '1;
      m.r = (w == 8) ? {24'b0, x[7:0]} : x[31:0];
      m.e = 1'b1;
    end else begin
      m.q = x / {32'b0, c};
      m.r = 32'(x % {32'b0, c});
      m.e = 1'b0;
    end
    return m;
  endfunction

  // hit >= 0: pulse start with other operands at that step
  task automatic op8(input logic [15:0] x, input logic [7:0] c,
                     input exp_t ex, input int hit,
                     input string nm);
    exp_t e;
    int   n;
    int   lat;
    sb8.push_back(ex);
    lat = (c == '0) ? 0 : 16;
    x8 = x;
    c8 = c;
    s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    x8 = 16'($urandom);
    c8 = 8'($urandom);
    chk({nm, "_busy"}, 64'(b8), 64'd1);
    n = 0;
    while (!d8 && n < 100) begin
      if (n == hit) begin
        s8 = 1'b1;
        x8 = 16'hFFFF;
        c8 = 8'd1;
      end else begin
        s8 = 1'b0;
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    s8 = 1'b0;
    e = sb8.pop_front();
    chk({nm, "_lat"}, 64'(n), 64'(lat));
    chk({nm, "_quo"}, 64'(q8), e.q);
    chk({nm, "_rem"}, 64'(r8), 64'(e.r));
    chk({nm, "_err"}, 64'(e8), 64'(e.e));
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(d8), 64'd0);
    chk({nm, "_busy_fall"}, 64'(b8), 64'd0);
    chk({nm, "_quo_hold"}, 64'(q8), e.q);
  endtask

  task automatic op32(input logic [63:0] x, input logic [31:0] c);
    exp_t e;
    int   n;
    sb32.push_back(model(x, c, 32));
    x32 = x;
    c32 = c;
    s32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s32 = 1'b0;
    x32 = {$urandom, $urandom};
    c32 = $urandom;
    n = 0;
    while (!d32 && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    e = sb32.pop_front();
    chk("r32_lat", 64'(n), (c == '0) ? 64'd0 : 64'd64);
    chk("r32_quo", q32, e.q);
    chk("r32_rem", 64'(r32), 64'(e.r));
    chk("r32_err", 64'(e32), 64'(e.e));
    if (c != '0) begin
      chk("r32_ident", q32 * {32'b0, c} + 64'(r32), x);
      chk("r32_lt", 64'(r32 < c), 64'd1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    exp_t ev;
    int   n;
    int   seen;
    logic [15:0] rx;
    logic [7:0]  rc;
    logic [63:0] wx;
    logic [31:0] wc;

    tbl.push_back('{16'h1234, 8'd7,   16'h0299, 8'h05, 1'b0});
    tbl.push_back('{16'hFFFE, 8'hFF,  16'h0100, 8'hFE, 1'b0});
    tbl.push_back('{16'h0005, 8'd200, 16'h0000, 8'h05, 1'b0});
    tbl.push_back('{16'hFFFF, 8'hFF,  16'h0101, 8'h00, 1'b0});
    tbl.push_back('{16'hABCD, 8'h00,  16'hFFFF, 8'hCD, 1'b1});
    tbl.push_back('{16'd100,  8'd9,   16'd11,   8'd1,  1'b0});
    tbl.push_back('{16'hFFFF, 8'd1,   16'hFFFF, 8'h00, 1'b0});
    tbl.push_back('{16'h00FF, 8'h80,  16'h0001, 8'h7F, 1'b0});
    tbl.push_back('{16'h0000, 8'd3,   16'h0000, 8'h00, 1'b0});
    tbl.push_back('{16'h8000, 8'hFF,  16'h0080, 8'h80, 1'b0});

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(b8), 64'd0);
    chk("rst_done", 64'(d8), 64'd0);
    chk("rst_err", 64'(e8), 64'd0);
    chk("rst_quo", 64'(q8), 64'd0);
    chk("rst_rem", 64'(r8), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      ev.q = 64'(tbl[i].q);
      ev.r = 32'(tbl[i].r);
      ev.e = tbl[i].e;
      op8(tbl[i].x, tbl[i].c, ev, -1, $sformatf("tbl%0d", i));
    end

    ev = '{64'h0299, 32'h05, 1'b0};
    op8(16'h1234, 8'd7, ev, 5, "ign_start");

    // Abort a run at step 9 with an asynchronous reset.
    x8 = 16'h1234;
    c8 = 8'd7;
    s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s8 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(b8), 64'd0);
    chk("arst_done", 64'(d8), 64'd0);
    chk("arst_quo", 64'(q8), 64'd0);
    chk("arst_rem", 64'(r8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (d8) seen++;
    end
    chk("arst_no_done", 64'(seen), 64'd0);
    ev = '{64'd11, 32'd1, 1'b0};
    op8(16'd100, 8'd9, ev, -1, "post_rst");

    // Start held high: re-accept on the first idle cycle.
    x8 = 16'd100;
    c8 = 8'd9;
    s8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!d8 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("hold_lat1", 64'(n), 64'd16);
    chk("hold_quo1", 64'(q8), 64'd11);
    x8 = 16'h1234;
    c8 = 8'd7;
    @(posedge clk);
    @(negedge clk);
    chk("hold_idle", 64'(b8), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("hold_reaccept", 64'(b8), 64'd1);
    s8 = 1'b0;
    n = 0;
    while (!d8 && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("hold_lat2", 64'(n), 64'd16);
    chk("hold_quo2", 64'(q8), 64'h0299);
    chk("hold_rem2", 64'(r8), 64'h05);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 1200; i++) begin
      rx = 16'($urandom);
      rc = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      op8(rx, rc, model(64'(rx), 32'(rc), 8), -1, "rnd8");
    end

    for (int i = 0; i < 350; i++) begin
      wx = {$urandom, $urandom};
      wc = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 31) == 0) wc = '0;
      op32(wx, wc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
